// File: rtl/crop_window_packer.sv
// Repacks the crop stage's sparse pixel/valid stream into a dense window stream
// tagged with window coordinates and frame markers, buffered in a show-ahead FIFO.
module crop_window_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int CROP_WIDTH  = 200,
    parameter int CROP_HEIGHT = 200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] m_pixel,
    output logic [9:0]            m_x,
    output logic [9:0]            m_y,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  short_frame
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] X_LAST = 10'(CROP_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(CROP_HEIGHT - 1);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PACK     = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pixel;
        logic [9:0]            x;
        logic [9:0]            y;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } entry_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  wx;
    logic [9:0]  wy;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic        restart;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        drop;
    logic        eol_cur;
    logic        eof_cur;
    logic        eof_write;
    logic        full;
    logic        empty;
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    entry_t      wr_entry;
    entry_t      head;
    entry_t      mem [FIFO_DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= WAIT_SOF;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SOF: if (frame_start) state_next = PACK;
            PACK: begin
                // A frame_start landing on the eof write opens the next frame directly.
                if (eof_write && (restart || !frame_start)) state_next = FLUSH;
            end
            FLUSH: begin
                if (frame_start) state_next = PACK;
                else if (empty)  state_next = WAIT_SOF;
            end
            default: state_next = WAIT_SOF;
        endcase
    end

    // Output / datapath control
    always_comb begin
        push_req   = (state == PACK) && in_valid;
        restart    = (state == PACK) && frame_start && !(in_valid && wx == X_LAST && wy == Y_LAST);
        cur_x      = restart ? 10'd0 : wx;
        cur_y      = restart ? 10'd0 : wy;
        eol_cur    = (cur_x == X_LAST);
        eof_cur    = eol_cur && (cur_y == Y_LAST);
        eof_write  = push_req && eof_cur;
        pop        = !empty && m_ready;
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        frame_done = (state == FLUSH) && empty && !frame_start;
        wr_entry   = '{pixel: in_pixel, x: cur_x, y: cur_y,
                       sof: (cur_x == 10'd0) && (cur_y == 10'd0),
                       eol: eol_cur, eof: eof_cur};
    end

    // Counters advance even when the pixel is dropped so geometry stays aligned.
    always_ff @(posedge clk) begin
        if (!rst_n || state != PACK || eof_write) begin
            wx <= 10'd0;
            wy <= 10'd0;
        end else if (push_req) begin
            if (eol_cur) begin
                wx <= 10'd0;
                wy <= cur_y + 10'd1;
            end else begin
                wx <= cur_x + 10'd1;
                wy <= cur_y;
            end
        end else if (restart) begin
            wx <= 10'd0;
            wy <= 10'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            overflow    <= overflow | drop;
            short_frame <= short_frame | restart;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wr_entry;
    end

    // Handshake: the head entry transfers on any edge where m_valid && m_ready;
    // while m_valid=1 and m_ready=0 the head and all m_* stay unchanged.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head    = mem[rptr[AW-1:0]];
    assign m_valid = !empty;
    assign m_pixel = empty ? '0    : head.pixel;
    assign m_x     = empty ? 10'd0 : head.x;
    assign m_y     = empty ? 10'd0 : head.y;
    assign m_sof   = !empty && head.sof;
    assign m_eol   = !empty && head.eol;
    assign m_eof   = !empty && head.eof;

endmodule

// File: doc/crop_window_packer.md
Name: crop_window_packer

Overview:
- Sits directly downstream of the crop stage.
- Accepts the sparse pixel/valid stream the crop stage produces during a full-frame raster scan and repacks it into a dense CROP_WIDTH x CROP_HEIGHT window stream.
- Attaches window-relative coordinates and frame markers to each pixel, and buffers the stream in a small FIFO.
- Presents the buffered stream on a valid/ready interface for consumers that can stall, such as a frame writer or link transmitter.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- CROP_WIDTH, 200, window width in pixels; range 1..1024.
- CROP_HEIGHT, 200, window height in lines; range 1..1024.
- FIFO_DEPTH, 16, entries in the output FIFO; must be a power of 2, minimum 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- frame_start  input  1  one-cycle pulse marking the start of a source frame.
- in_pixel  input  DATA_WIDTH  pixel from the crop stage.
- in_valid  input  1  in_pixel carries a window pixel this cycle.
- m_pixel  output  DATA_WIDTH  pixel at the FIFO head.
- m_x  output  10  window column of the head pixel.
- m_y  output  10  window row of the head pixel.
- m_sof  output  1  head pixel is (0,0).
- m_eol  output  1  head pixel is the last pixel of its row.
- m_eof  output  1  head pixel is the last pixel of the window.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accepts the head entry when m_valid=1.
- frame_done  output  1  one-cycle pulse when a complete window has drained.
- overflow  output  1  sticky flag: an input pixel was dropped.
- short_frame  output  1  sticky flag: a frame restarted before it completed.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=WAIT_SOF; write counters wx=wy=0; FIFO emptied.
  - m_valid=0, frame_done=0, overflow=0, short_frame=0.
  - m_pixel, m_x, m_y, m_sof, m_eol, m_eof read 0.
  - Reset has priority over every other input.
- State machine:
  - WAIT_SOF: in_valid ignored; no write. On frame_start: wx=wy=0, go to PACK.
  - PACK: each in_valid cycle writes entry {in_pixel, wx, wy, sof, eol, eof}.
    - sof=(wx==0 && wy==0); eol=(wx==CROP_WIDTH-1); eof=(eol && wy==CROP_HEIGHT-1).
    - After the write: if eol, wx=0 and wy=wy+1; otherwise wx=wx+1.
    - On the eof write, go to FLUSH and clear both counters.
  - FLUSH: in_valid ignored. When FIFO empty, pulse frame_done for 1 cycle and go to WAIT_SOF.
- frame_start in PACK with no concurrent eof write:
  - Set short_frame; wx=wy=0; stay in PACK.
  - Entries already queued are kept and drain normally.
  - An in_valid in the same cycle is written as (0,0) with sof=1.
- frame_start in FLUSH: go to PACK with counters 0, no frame_done pulse; queued entries still drain.
- frame_start concurrent with the eof write: the eof write completes, then state goes to PACK, not FLUSH.
- FIFO:
  - Show-ahead: m_* reflect the head entry combinationally from storage; m_valid = !empty.
  - Pop when m_valid && m_ready.
  - Push when state is PACK and in_valid, subject to the full rule below.
  - Write latency: a pixel written into an empty FIFO at edge N appears with m_valid=1 after edge N.
- Full FIFO:
  - A push while full with no pop in the same cycle drops the pixel and sets overflow.
  - Counters still advance and markers/state transitions proceed, so window geometry stays aligned.
  - Push while full with a pop in the same cycle is accepted; occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO: pop is not valid (m_valid=0); push proceeds.
- m_* must hold stable while m_valid=1 and m_ready=0.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB compare.
- Counters: 10-bit; no arithmetic beyond +1 and equality compares.

Test Plan:
- CROP_WIDTH=4, CROP_HEIGHT=3, FIFO_DEPTH=4, m_ready=1; frame_start, then 12 in_valid pixels 0x10..0x1B:
  - 12 outputs in order with (m_x,m_y) running (0,0)..(3,2).
  - m_sof only on 0x10; m_eol on 0x13, 0x17, 0x1B; m_eof only on 0x1B.
  - One frame_done pulse after the last pop.
- Same stimulus with m_ready=0 throughout:
  - First 4 pixels are queued and overflow=1 from the 5th.
  - Releasing m_ready yields 0x10..0x13 with coordinates (0,0)..(3,0).
  - Next frame_start, then 12 pixels with m_ready=1, gives correct (0,0) start.
- in_valid pulses before any frame_start -> m_valid stays 0, nothing is written.
- frame_start after 6 pixels -> short_frame=1; the next pixel is emitted as (0,0) with m_sof=1; 12 more pixels complete the frame with frame_done.
- FIFO full (4 entries), m_ready=1 and in_valid=1 in the same cycle -> both accepted, overflow stays 0, occupancy stays 4.
- rst_n=0 for one cycle mid-frame with the FIFO holding 3 entries -> next cycle m_valid=0 and all flags 0; in_valid is ignored until frame_start.
